// File: rtl/fu_broadcast_arbiter.sv
// Round-robin arbiter that collects functional-unit results into a broadcast FIFO
// and drains the FIFO onto the common data bus, one entry per cycle.
module fu_broadcast_arbiter #(
    parameter int NUM_FU     = 4,
    parameter int DATA_WIDTH = 32,
    parameter int TAG_WIDTH  = 7,
    parameter int DEPTH      = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_FU-1:0]            fu_done,
    input  logic [NUM_FU*DATA_WIDTH-1:0] fu_result,
    input  logic [NUM_FU*TAG_WIDTH-1:0]  fu_tag,
    output logic [NUM_FU-1:0]            fu_queued,
    output logic                         cdb_valid,
    output logic [TAG_WIDTH-1:0]         cdb_tag,
    output logic [DATA_WIDTH-1:0]        cdb_data,
    input  logic                         cdb_stall,
    output logic [$clog2(DEPTH):0]       count,
    output logic                         full,
    output logic                         empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int GW = $clog2(NUM_FU);
    localparam int EW = TAG_WIDTH + DATA_WIDTH;

    logic [GW-1:0] rr_ptr;
    logic [GW-1:0] grant_idx;
    logic          grant_any;
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count_q;
    logic [EW-1:0] mem [DEPTH];
    logic [EW-1:0] push_entry;
    logic          push;
    logic          pop;

    assign count     = count_q;
    assign full      = (count_q == CW'(DEPTH));
    assign empty     = (count_q == '0);
    assign cdb_valid = ~empty;
    assign cdb_tag   = mem[head][EW-1:DATA_WIDTH];
    assign cdb_data  = mem[head][DATA_WIDTH-1:0];

    // A full FIFO refuses pushes even when a pop is pending, so the grant never depends on cdb_stall.
    always_comb begin
        int idx;
        idx       = 0;
        grant_any = 1'b0;
        grant_idx = '0;
        fu_queued = '0;
        if (rst && !full) begin
            for (int k = 0; k < NUM_FU; k++) begin
                idx = (int'(rr_ptr) + k) % NUM_FU;
                if (fu_done[idx] && !grant_any) begin
                    grant_any = 1'b1;
                    grant_idx = GW'(idx);
                end
            end
            fu_queued[grant_idx] = grant_any;
        end
    end

    assign push       = grant_any;
    assign pop        = cdb_valid & ~cdb_stall;
    assign push_entry = {fu_tag[grant_idx*TAG_WIDTH +: TAG_WIDTH],
                         fu_result[grant_idx*DATA_WIDTH +: DATA_WIDTH]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head    <= '0;
            tail    <= '0;
            count_q <= '0;
            rr_ptr  <= '0;
        end else begin
            if (push) begin
                tail   <= tail + PW'(1);
                rr_ptr <= (grant_idx == GW'(NUM_FU - 1)) ? '0 : grant_idx + GW'(1);
            end
            if (pop) begin
                head <= head + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage is not reset; the count alone decides which slots hold live entries.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[tail] <= push_entry;
        end
    end

endmodule

// File: tb/tb_fu_broadcast_arbiter.sv
// Bench for fu_broadcast_arbiter: directed scenarios followed by a randomized run
// checked against a queue-based reference model of the arbiter and FIFO.
module tb_fu_broadcast_arbiter;

    localparam int NUM_FU = 4;
    localparam int DW     = 32;
    localparam int TW     = 7;
    localparam int DEPTH  = 8;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NUM_FU-1:0]    fu_done;
    logic [NUM_FU*DW-1:0] fu_result;
    logic [NUM_FU*TW-1:0] fu_tag;
    logic [NUM_FU-1:0]    fu_queued;
    logic                 cdb_valid;
    logic [TW-1:0]        cdb_tag;
    logic [DW-1:0]        cdb_data;
    logic                 cdb_stall;
    logic [3:0]           count;
    logic                 full;
    logic                 empty;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fu_broadcast_arbiter #(
        .NUM_FU(NUM_FU), .DATA_WIDTH(DW), .TAG_WIDTH(TW), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .fu_done(fu_done), .fu_result(fu_result), .fu_tag(fu_tag),
        .fu_queued(fu_queued), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .cdb_stall(cdb_stall), .count(count), .full(full), .empty(empty)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_fu(input int i, input logic [TW-1:0] t, input logic [DW-1:0] d);
        fu_tag[i*TW +: TW]    = t;
        fu_result[i*DW +: DW] = d;
    endtask

    task automatic do_reset();
        rst       = 1'b0;
        fu_done   = '0;
        cdb_stall = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst     = 1'b0;
        fu_done = 4'b1111;
        #1;
        checks++; if (fu_queued !== 4'b0000) begin errors++; $display("FAIL rst_queued got=%b exp=0000", fu_queued); end
        checks++; if (cdb_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got=%b exp=0", cdb_valid); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL rst_empty got=%b exp=1", empty); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL rst_full got=%b exp=0", full); end
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL rst_count got=%0d exp=0", count); end
        tick();
        checks++; if (fu_queued !== 4'b0000) begin errors++; $display("FAIL rst_queued_edge got=%b exp=0000", fu_queued); end
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL rst_count_edge got=%0d exp=0", count); end
        fu_done = '0;
        rst     = 1'b1;
        tick();
    endtask

    task automatic test_single();
        do_reset();
        set_fu(0, 7'h05, 32'hDEADBEEF);
        fu_done = 4'b0001;
        #1;
        checks++; if (fu_queued !== 4'b0001) begin errors++; $display("FAIL single_grant got=%b exp=0001", fu_queued); end
        checks++; if (cdb_valid !== 1'b0) begin errors++; $display("FAIL single_nobypass got=%b exp=0", cdb_valid); end
        tick();
        fu_done = '0;
        #1;
        checks++; if (cdb_valid !== 1'b1) begin errors++; $display("FAIL single_valid got=%b exp=1", cdb_valid); end
        checks++; if (cdb_tag !== 7'h05) begin errors++; $display("FAIL single_tag got=%h exp=05", cdb_tag); end
        checks++; if (cdb_data !== 32'hDEADBEEF) begin errors++; $display("FAIL single_data got=%h exp=deadbeef", cdb_data); end
        checks++; if (count !== 4'd1) begin errors++; $display("FAIL single_count got=%0d exp=1", count); end
        tick();
        #1;
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL single_drain got=%b exp=1", empty); end
        checks++; if (cdb_valid !== 1'b0) begin errors++; $display("FAIL single_drain_valid got=%b exp=0", cdb_valid); end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp;
        do_reset();
        cdb_stall = 1'b1;
        for (int i = 0; i < NUM_FU; i++) set_fu(i, 7'(16 + i), 32'hA0000000 + i);
        fu_done = 4'b1111;
        for (int k = 0; k < NUM_FU; k++) begin
            #1;
            exp = 4'b0001 << k;
            checks++; if (fu_queued !== exp) begin errors++; $display("FAIL rr_grant%0d got=%b exp=%b", k, fu_queued, exp); end
            tick();
            fu_done[k] = 1'b0;
        end
        #1;
        checks++; if (count !== 4'd4) begin errors++; $display("FAIL rr_count got=%0d exp=4", count); end
        checks++; if (fu_queued !== 4'b0000) begin errors++; $display("FAIL rr_idle got=%b exp=0000", fu_queued); end
        cdb_stall = 1'b0;
        for (int k = 0; k < NUM_FU; k++) begin
            #1;
            checks++; if (cdb_tag !== 7'(16 + k)) begin errors++; $display("FAIL rr_pop_tag%0d got=%h exp=%h", k, cdb_tag, 7'(16 + k)); end
            checks++; if (cdb_data !== 32'hA0000000 + k) begin errors++; $display("FAIL rr_pop_data%0d got=%h", k, cdb_data); end
            tick();
        end
        #1;
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL rr_empty got=%b exp=1", empty); end
    endtask

    task automatic test_fairness();
        logic [3:0] exp;
        do_reset();
        set_fu(1, 7'h11, 32'h1111);
        set_fu(3, 7'h33, 32'h3333);
        for (int k = 0; k < 7; k++) begin
            fu_done = (k == 0) ? 4'b1000 : 4'b1010;
            #1;
            exp = (k % 2 == 0) ? 4'b1000 : 4'b0010;
            checks++; if (fu_queued !== exp) begin errors++; $display("FAIL fair_grant%0d got=%b exp=%b", k, fu_queued, exp); end
            tick();
        end
        fu_done = '0;
        repeat (3) tick();
    endtask

    task automatic test_full();
        do_reset();
        cdb_stall = 1'b1;
        fu_done   = 4'b0001;
        for (int k = 0; k < DEPTH; k++) begin
            set_fu(0, 7'(k), 32'hF0000000 + k);
            #1;
            checks++; if (fu_queued !== 4'b0001) begin errors++; $display("FAIL full_fill%0d got=%b exp=0001", k, fu_queued); end
            tick();
        end
        set_fu(0, 7'd8, 32'hF0000008);
        #1;
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL full_flag got=%b exp=1", full); end
        checks++; if (count !== 4'd8) begin errors++; $display("FAIL full_count got=%0d exp=8", count); end
        checks++; if (fu_queued !== 4'b0000) begin errors++; $display("FAIL full_block got=%b exp=0000", fu_queued); end
        cdb_stall = 1'b0;
        #1;
        checks++; if (fu_queued !== 4'b0000) begin errors++; $display("FAIL full_block_pop got=%b exp=0000", fu_queued); end
        checks++; if (cdb_tag !== 7'd0) begin errors++; $display("FAIL full_head got=%h exp=00", cdb_tag); end
        tick();
        cdb_stall = 1'b1;
        #1;
        checks++; if (count !== 4'd7) begin errors++; $display("FAIL full_after_pop got=%0d exp=7", count); end
        checks++; if (fu_queued !== 4'b0001) begin errors++; $display("FAIL full_regrant got=%b exp=0001", fu_queued); end
        tick();
        fu_done = '0;
        #1;
        checks++; if (count !== 4'd8) begin errors++; $display("FAIL full_refill got=%0d exp=8", count); end
        cdb_stall = 1'b0;
        for (int k = 1; k <= DEPTH; k++) begin
            #1;
            checks++; if (cdb_tag !== 7'(k)) begin errors++; $display("FAIL full_wrap_tag%0d got=%h exp=%h", k, cdb_tag, 7'(k)); end
            checks++; if (cdb_data !== 32'hF0000000 + k) begin errors++; $display("FAIL full_wrap_data%0d got=%h", k, cdb_data); end
            tick();
        end
        #1;
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL full_empty got=%b exp=1", empty); end
    endtask

    task automatic test_push_pop();
        do_reset();
        cdb_stall = 1'b1;
        fu_done   = 4'b0001;
        for (int k = 0; k < 3; k++) begin
            set_fu(0, 7'(32 + k), 32'hC0000000 + k);
            #1;
            tick();
        end
        set_fu(0, 7'd35, 32'hC0000003);
        cdb_stall = 1'b0;
        #1;
        checks++; if (count !== 4'd3) begin errors++; $display("FAIL pp_count_before got=%0d exp=3", count); end
        checks++; if (cdb_tag !== 7'd32) begin errors++; $display("FAIL pp_oldest got=%h exp=20", cdb_tag); end
        checks++; if (fu_queued !== 4'b0001) begin errors++; $display("FAIL pp_grant got=%b exp=0001", fu_queued); end
        tick();
        fu_done   = '0;
        cdb_stall = 1'b1;
        #1;
        checks++; if (count !== 4'd3) begin errors++; $display("FAIL pp_count_after got=%0d exp=3", count); end
        cdb_stall = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            #1;
            checks++; if (cdb_tag !== 7'(32 + k)) begin errors++; $display("FAIL pp_order%0d got=%h exp=%h", k, cdb_tag, 7'(32 + k)); end
            tick();
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        cdb_stall = 1'b1;
        fu_done   = 4'b0100;
        for (int k = 0; k < 5; k++) begin
            set_fu(2, 7'(48 + k), 32'hB0000000 + k);
            #1;
            tick();
        end
        fu_done = '0;
        #1;
        checks++; if (count !== 4'd5) begin errors++; $display("FAIL ar_count_pre got=%0d exp=5", count); end
        #1;
        set_fu(1, 7'h41, 32'h41414141);
        set_fu(3, 7'h43, 32'h43434343);
        rst     = 1'b0;
        fu_done = 4'b1110;
        #1;
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL ar_count got=%0d exp=0", count); end
        checks++; if (cdb_valid !== 1'b0) begin errors++; $display("FAIL ar_valid got=%b exp=0", cdb_valid); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL ar_full got=%b exp=0", full); end
        checks++; if (fu_queued !== 4'b0000) begin errors++; $display("FAIL ar_queued got=%b exp=0000", fu_queued); end
        tick();
        rst = 1'b1;
        #1;
        checks++; if (fu_queued !== 4'b0010) begin errors++; $display("FAIL ar_first_grant got=%b exp=0010", fu_queued); end
        checks++; if (cdb_valid !== 1'b0) begin errors++; $display("FAIL ar_discard got=%b exp=0", cdb_valid); end
        tick();
        fu_done = 4'b1100;
        #1;
        checks++; if (fu_queued !== 4'b0100) begin errors++; $display("FAIL ar_second_grant got=%b exp=0100", fu_queued); end
        checks++; if (cdb_tag !== 7'h41) begin errors++; $display("FAIL ar_head got=%h exp=41", cdb_tag); end
        fu_done   = '0;
        cdb_stall = 1'b0;
        repeat (4) tick();
    endtask

    task automatic test_random();
        logic [TW+DW-1:0] q[$];
        logic [TW+DW-1:0] head_m;
        logic [3:0]       eg;
        int               rr_m;
        int               gi;
        int               idx;
        do_reset();
        rr_m = 0;
        for (int cyc = 0; cyc < 3000 && errors < 40; cyc++) begin
            for (int i = 0; i < NUM_FU; i++) begin
                if (!fu_done[i] && $urandom_range(0, 2) == 0) begin
                    set_fu(i, 7'($urandom), $urandom);
                    fu_done[i] = 1'b1;
                end
            end
            if ((cyc / 200) % 2 == 1) cdb_stall = ($urandom_range(0, 3) != 0);
            else                      cdb_stall = ($urandom_range(0, 3) == 0);
            #1;
            gi = -1;
            if (q.size() < DEPTH) begin
                for (int k = 0; k < NUM_FU; k++) begin
                    idx = (rr_m + k) % NUM_FU;
                    if (gi < 0 && fu_done[idx]) gi = idx;
                end
            end
            eg = '0;
            if (gi >= 0) eg[gi] = 1'b1;
            checks++; if (fu_queued !== eg) begin errors++; $display("FAIL rnd_grant cyc=%0d got=%b exp=%b", cyc, fu_queued, eg); end
            checks++; if (count !== 4'(q.size())) begin errors++; $display("FAIL rnd_count cyc=%0d got=%0d exp=%0d", cyc, count, q.size()); end
            checks++; if (cdb_valid !== (q.size() != 0)) begin errors++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", cyc, cdb_valid, q.size() != 0); end
            checks++; if (full !== (q.size() == DEPTH)) begin errors++; $display("FAIL rnd_full cyc=%0d got=%b exp=%b", cyc, full, q.size() == DEPTH); end
            checks++; if (empty !== (q.size() == 0)) begin errors++; $display("FAIL rnd_empty cyc=%0d got=%b exp=%b", cyc, empty, q.size() == 0); end
            if (q.size() != 0) begin
                head_m = q[0];
                checks++; if ({cdb_tag, cdb_data} !== head_m) begin errors++; $display("FAIL rnd_head cyc=%0d got=%h_%h exp=%h", cyc, cdb_tag, cdb_data, head_m); end
            end
            if (q.size() != 0 && !cdb_stall) void'(q.pop_front());
            if (gi >= 0) begin
                q.push_back({fu_tag[gi*TW +: TW], fu_result[gi*DW +: DW]});
                rr_m = (gi + 1) % NUM_FU;
            end
            tick();
            if (gi >= 0) fu_done[gi] = 1'b0;
        end
        fu_done   = '0;
        cdb_stall = 1'b0;
        repeat (DEPTH + 2) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        fu_done   = '0;
        fu_result = '0;
        fu_tag    = '0;
        cdb_stall = 1'b0;
        #2;
        test_reset();
        test_single();
        test_round_robin();
        test_fairness();
        test_full();
        test_push_pop();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fu_broadcast_arbiter.md
Name: fu_broadcast_arbiter

Overview:
- Collects completed results from NUM_FU functional units and arbitrates them round-robin into a shared broadcast FIFO.
- Drains the FIFO onto the common data bus (CDB), one entry per cycle.
- Sits between the FU bank and the CDB consumers (reservation stations, ROB).
- Drives each FU's queued input, which is the FU's condition for returning to idle.

Parameters:
- NUM_FU, 4, number of functional-unit requesters (>=2).
- DATA_WIDTH, 32, result width.
- TAG_WIDTH, 7, execution tag width.
- DEPTH, 8, FIFO entries (power of 2, >=2).

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- fu_done  input  NUM_FU  bit i: FU i has a result; held high until fu_queued[i] is seen.
- fu_result  input  NUM_FU*DATA_WIDTH  FU i result at bits [i*DATA_WIDTH +: DATA_WIDTH].
- fu_tag  input  NUM_FU*TAG_WIDTH  FU i execution tag at bits [i*TAG_WIDTH +: TAG_WIDTH].
- fu_queued  output  NUM_FU  one-hot or zero; combinational grant, FU i's entry is written at this edge.
- cdb_valid  output  1  head entry valid.
- cdb_tag  output  TAG_WIDTH  head entry tag.
- cdb_data  output  DATA_WIDTH  head entry result.
- cdb_stall  input  1  consumer not ready; head is held.
- count  output  $clog2(DEPTH)+1  current occupancy.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.

Behaviour:
- Reset (rst low, asynchronous):
  - head, tail, count and rr_ptr cleared to 0.
  - cdb_valid = 0, empty = 1, full = 0, fu_queued = 0.
  - FIFO storage need not be cleared. cdb_tag/cdb_data are don't-care while cdb_valid = 0.
- Reset asserted mid-operation discards all queued entries. No grant is issued in a cycle while rst is low.
- Arbitration (combinational):
  - If full, fu_queued = 0.
  - Otherwise, grant the first i with fu_done[i] = 1, searching from rr_ptr upward modulo NUM_FU.
  - At most one grant per cycle.
- rr_ptr updates on a grant only: rr_ptr <= (granted index + 1) mod NUM_FU. With no grant, rr_ptr holds.
- Push: on a grant, write {fu_tag[g], fu_result[g]} at tail, and tail <= tail + 1 (wraps mod DEPTH).
- Pop:
  - pop = cdb_valid & ~cdb_stall; head <= head + 1 (wraps mod DEPTH).
  - cdb_valid = ~empty. cdb_tag/cdb_data read the head slot combinationally from registered storage.
- Occupancy:
  - count <= count + push - pop.
  - Push and pop in the same cycle leave count unchanged.
- Latency:
  - A grant at edge N makes the entry visible at the head after edge N if the FIFO was empty: cdb_valid = 1 in cycle N+1.
  - There is no same-cycle bypass.
- Full: no push, even if a pop occurs in the same cycle. This keeps fu_queued independent of cdb_stall.
- Empty: pop is impossible because cdb_valid = 0. cdb_stall is ignored.
- Pointer wrap: head and tail are $clog2(DEPTH) bits and wrap naturally. Full/empty come from count only.
- Requesters that are not granted keep fu_done high and are retried every cycle. The arbiter never drops a held request.
- The FU contract is that fu_done[i] and the captured data stay stable until fu_queued[i] = 1. The FU deasserts done after that edge.
- Data integrity: entries leave the FIFO in push order. Tag and data are always paired from the same FU.

Test Plan:
- Single request: reset, then fu_done = 0001, tag 0x05, data 0xDEADBEEF for 1 cycle -> fu_queued = 0001 in the same cycle. Next cycle: cdb_valid = 1, cdb_tag = 0x05, cdb_data = 0xDEADBEEF, count = 1. With cdb_stall = 0, empty one cycle later.
- Round-robin: fu_done = 1111 held, cdb_stall = 1 -> grants 0,1,2,3 on successive cycles. Each FU then drops its done after its grant. CDB pops in order tag0..tag3 once cdb_stall = 0.
- Fairness after reset: rr_ptr = 0 and FU3 requesting continuously while FU1 joins -> FU1 is granted before FU3 repeats. Pattern: 3,1,3,1...
- Full: cdb_stall = 1, push 8 entries -> full = 1, count = 8, fu_queued = 0 despite fu_done = 0001. Release cdb_stall for one cycle -> pop, then FU0 granted the next cycle. Order preserved across wrap.
- Simultaneous push/pop at count = 3 with cdb_stall = 0 -> count stays 3. The popped entry is the oldest.
- Async reset: assert rst low mid-cycle with count = 5 -> cdb_valid, count, full and fu_queued drop immediately, without waiting for a clock edge. After release, the first grant goes to the lowest-indexed requester.
